// File: rtl/fwd_pkg.sv
// Shared types and encodings for the operand-forwarding / load-use hazard unit.
// Forward-select codes are shared by the top level and the per-source matcher.
package fwd_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  localparam int FWD_SEL_W = 2;

endpackage

// File: rtl/fwd_src_match.sv
// Forward-select for a single EX source operand; purely combinational.
// The EXMEM producer is newer than MEMWB, so it wins when both write the register.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic [REG_AW-1:0] src,
  input  logic              exmem_vld,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              memwb_vld,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  output fwd_sel_t          sel
);

  logic src_live;
  logic exmem_hit;
  logic memwb_hit;

  // A hard-wired zero register never carries a value worth forwarding.
  assign src_live  = !((ZERO_REG != 0) && (src == '0));
  assign exmem_hit = src_live && exmem_vld && exmem_regwrite && (exmem_rd == src);
  assign memwb_hit = src_live && memwb_vld && memwb_regwrite && (memwb_rd == src);

  always_comb begin
    sel = FWD_RF;
    if (exmem_hit) begin
      sel = FWD_MEM;
    end else if (memwb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks the IDEX/EXMEM/MEMWB destination info to drive operand forwarding and
// one-cycle load-use stalls; outputs are combinational from state plus ID inputs.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 2,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic                      flush,
  input  logic                      hold,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt
);

  typedef struct packed {
    logic                      vld;
    logic [REG_AW-1:0]         rd;
    logic                      regwrite;
    logic                      memread;
    logic [NUM_SRC*REG_AW-1:0] src;
  } idex_t;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } stage_t;

  idex_t             idex_q,  idex_d;
  stage_t            exmem_q, exmem_d;
  stage_t            memwb_q, memwb_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0] src_hit;
  logic               load_use;
  idex_t              id_ent;
  logic               memwb_memread_unused;

  assign memwb_memread_unused = memwb_q.memread;

  // Load-use: the instruction in EX is a load whose result an ID source needs.
  always_comb begin
    src_hit = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src_hit[k] = (id_src[k*REG_AW +: REG_AW] == idex_q.rd) &&
                   !((ZERO_REG != 0) && (id_src[k*REG_AW +: REG_AW] == '0));
    end
    load_use = id_valid && idex_q.vld && idex_q.regwrite && idex_q.memread &&
               (|src_hit);
  end

  assign stall     = load_use;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    id_ent          = '0;
    id_ent.vld      = 1'b1;
    id_ent.rd       = id_rd;
    id_ent.regwrite = id_regwrite;
    id_ent.memread  = id_memread;
    id_ent.src      = id_src;
  end

  always_comb begin
    idex_d      = idex_q;
    exmem_d     = exmem_q;
    memwb_d     = memwb_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      memwb_d          = exmem_q;
      exmem_d.vld      = idex_q.vld;
      exmem_d.rd       = idex_q.rd;
      exmem_d.regwrite = idex_q.regwrite;
      exmem_d.memread  = idex_q.memread;
      // Bubbles are fully zeroed so stale IDs can never match downstream.
      if (flush || load_use || !id_valid) begin
        idex_d = '0;
      end else begin
        idex_d = id_ent;
      end
      if (!flush && load_use && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_src_match #(
      .REG_AW   (REG_AW),
      .ZERO_REG (ZERO_REG)
    ) u_match (
      .src            (idex_q.src[k*REG_AW +: REG_AW]),
      .exmem_vld      (exmem_q.vld),
      .exmem_regwrite (exmem_q.regwrite),
      .exmem_rd       (exmem_q.rd),
      .memwb_vld      (memwb_q.vld),
      .memwb_regwrite (memwb_q.regwrite),
      .memwb_rd       (memwb_q.rd),
      .sel            (fwd_sel[FWD_SEL_W*k +: FWD_SEL_W])
    );
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed vector table, saturation/reset corner
// sequences, then random traffic checked against a stage-array reference model.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [7:0]  id_src;
  logic [3:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        flush;
  logic        hold;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .hold        (hold),
    .fwd_sel     (fwd_sel),
    .stall       (stall),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  s0, s1, rd;
    logic        rw, mr, fl, hd;
    logic [3:0]  e_sel;
    logic        e_stall;
    logic [15:0] e_cnt;
  } vec_t;

  // Reference model: index 0 = IDEX, 1 = EXMEM, 2 = MEMWB.
  typedef struct {
    bit vld;
    int rd;
    bit rw;
    bit mr;
    int s0;
    int s1;
  } ment_t;

  ment_t pipe [3];
  int    mcnt;

  function automatic vec_t mk(int v, int s0, int s1, int rd, int rw, int mr,
                              int fl, int hd, int esel, int estall, int ecnt);
    vec_t r;
    r.v = 1'(v);  r.s0 = 4'(s0); r.s1 = 4'(s1); r.rd = 4'(rd);
    r.rw = 1'(rw); r.mr = 1'(mr); r.fl = 1'(fl); r.hd = 1'(hd);
    r.e_sel = 4'(esel); r.e_stall = 1'(estall); r.e_cnt = 16'(ecnt);
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t in);
    id_valid    = in.v;
    id_src      = {in.s1, in.s0};
    id_rd       = in.rd;
    id_regwrite = in.rw;
    id_memread  = in.mr;
    flush       = in.fl;
    hold        = in.hd;
  endtask

  task automatic model_reset();
    for (int j = 0; j < 3; j++) pipe[j] = '{0, 0, 0, 0, 0, 0};
    mcnt = 0;
  endtask

  // Newest older stage that writes the register supplies the value.
  function automatic int model_fwd(int s);
    if (s == 0) return 0;
    if (pipe[1].vld && pipe[1].rw && pipe[1].rd == s) return 2;
    if (pipe[2].vld && pipe[2].rw && pipe[2].rd == s) return 1;
    return 0;
  endfunction

  function automatic int model_sel();
    return model_fwd(pipe[0].s1) * 4 + model_fwd(pipe[0].s0);
  endfunction

  function automatic bit model_stall(vec_t in);
    bit need;
    need = (in.s0 != 0 && int'(in.s0) == pipe[0].rd) ||
           (in.s1 != 0 && int'(in.s1) == pipe[0].rd);
    return in.v && pipe[0].vld && pipe[0].rw && pipe[0].mr && need;
  endfunction

  task automatic model_step(input vec_t in);
    bit st;
    st = model_stall(in);
    if (!in.hd) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (in.fl || st || !in.v) pipe[0] = '{0, 0, 0, 0, 0, 0};
      else pipe[0] = '{1, int'(in.rd), in.rw, in.mr, int'(in.s0), int'(in.s1)};
      if (!in.fl && st && mcnt < 65535) mcnt++;
    end
  endtask

  task automatic tcycle(input vec_t in, input int idx);
    @(negedge clk);
    apply(in);
    #1;
    chk($sformatf("tbl[%0d].fwd_sel", idx), int'(fwd_sel), int'(in.e_sel));
    chk($sformatf("tbl[%0d].stall", idx), int'(stall), int'(in.e_stall));
    chk($sformatf("tbl[%0d].stall_cnt", idx), int'(stall_cnt), int'(in.e_cnt));
    model_step(in);
  endtask

  task automatic mcycle(input vec_t in, input string tag);
    @(negedge clk);
    apply(in);
    #1;
    chk({tag, ".fwd_sel"}, int'(fwd_sel), model_sel());
    chk({tag, ".stall"}, int'(stall), int'(model_stall(in)));
    chk({tag, ".stall_cnt"}, int'(stall_cnt), mcnt);
    model_step(in);
  endtask

  vec_t tbl [31];
  vec_t ld, use_, idle, rv, last;
  bit   last_stall;

  initial begin
    int n;
    n = 0;
    tbl[n++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    tbl[n++] = mk(1, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0);         // writer rd=12
    tbl[n++] = mk(1, 12, 15, 0, 0, 0, 0, 0, 0, 0, 0);        // reader 12,15
    tbl[n++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 0);
    tbl[n++] = mk(1, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0);         // writer rd=13
    tbl[n++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[n++] = mk(1, 0, 13, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[n++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 0, 0);
    tbl[n++] = mk(1, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0);         // rd=13, no write
    tbl[n++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[n++] = mk(1, 0, 13, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[n++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    tbl[n++] = mk(1, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0);         // two writers of 12
    tbl[n++] = mk(1, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0);
    tbl[n++] = mk(1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[n++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 0);
    tbl[n++] = mk(1, 0, 0, 11, 1, 1, 0, 0, 0, 0, 0);         // load rd=11
    tbl[n++] = mk(1, 11, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[n++] = mk(1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[n++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 1);
    tbl[n++] = mk(1, 0, 0, 11, 1, 1, 0, 0, 0, 0, 1);         // load, then flushed use
    tbl[n++] = mk(1, 11, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    tbl[n++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[n++] = mk(1, 0, 0, 11, 1, 1, 0, 0, 0, 0, 1);         // load, then held use
    tbl[n++] = mk(1, 11, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    tbl[n++] = mk(1, 11, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    tbl[n++] = mk(1, 11, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[n++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    tbl[n++] = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2);          // load to r0
    tbl[n++] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    tbl[n++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(idle);
    rst = 1'b1;
    model_reset();
    #12;
    chk("reset.fwd_sel", int'(fwd_sel), 0);
    chk("reset.stall", int'(stall), 0);
    chk("reset.stall_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < n; i++) tcycle(tbl[i], i);

    // Counter saturation: preset just below all-ones, then two more stalls.
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    mcnt = 16'hFFFE;
    ld   = mk(1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
    use_ = mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      mcycle(ld, "sat.load");
      mcycle(use_, "sat.use");
      mcycle(idle, "sat.idle");
    end
    chk("sat.final", int'(stall_cnt), 16'hFFFF);

    // Reset asserted in the middle of a stall cancels it immediately.
    ld   = mk(1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0);
    use_ = mk(1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    mcycle(ld, "rstmid.load");
    @(negedge clk);
    apply(use_);
    #1;
    chk("rstmid.stall_before", int'(stall), 1);
    rst = 1'b1;
    #1;
    chk("rstmid.stall", int'(stall), 0);
    chk("rstmid.fwd_sel", int'(fwd_sel), 0);
    chk("rstmid.stall_cnt", int'(stall_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(idle);
    mcycle(idle, "rstmid.idle");

    // Random traffic over a small register range so hazards are frequent.
    last = idle;
    last_stall = 0;
    for (int c = 0; c < 800; c++) begin
      if (last_stall && $urandom_range(0, 3) != 0) begin
        rv = last;
      end else begin
        rv = idle;
        rv.v  = ($urandom_range(0, 9) < 8);
        rv.s0 = 4'($urandom_range(0, 3));
        rv.s1 = 4'($urandom_range(0, 3));
        rv.rd = 4'($urandom_range(0, 3));
        rv.rw = ($urandom_range(0, 9) < 7);
        rv.mr = ($urandom_range(0, 9) < 4);
      end
      rv.fl = ($urandom_range(0, 15) == 0);
      rv.hd = ($urandom_range(0, 7) == 0);
      last_stall = model_stall(rv) && !rv.fl;
      last = rv;
      mcycle(rv, $sformatf("rand[%0d]", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter REG_AW, default 4, register-address width.
REQ-002 Parameter NUM_SRC, default 2, source operands per instruction.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 is hard-wired and never forwarded or stalled on.
REQ-004 Parameter CNT_W, default 16, stall-counter width.
REQ-005 Port clk, input, 1, the single clock; every state element is on its rising edge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Port id_valid, input, 1, an instruction is present in the ID stage.
REQ-008 Port id_src, input, NUM_SRC*REG_AW, packed source register IDs of the ID instruction; source k occupies bits [k*REG_AW +: REG_AW].
REQ-009 Port id_rd, input, REG_AW, destination register of the ID instruction.
REQ-010 Port id_regwrite, input, 1, the ID instruction writes id_rd.
REQ-011 Port id_memread, input, 1, the ID instruction is a load.
REQ-012 Port flush, input, 1, squashes the ID instruction (branch redirect).
REQ-013 Port hold, input, 1, global freeze (memory wait).
REQ-014 Port fwd_sel, output, 2*NUM_SRC, per-source forward select for the instruction in EX.
REQ-015 Port stall, output, 1, load-use stall request to the fetch/ID stage.
REQ-016 Port stall_cnt, output, CNT_W, saturating count of load-use stall cycles.

Function
REQ-017 The unit shall keep three internal entries, IDEX, EXMEM and MEMWB, each holding valid, rd, regwrite and memread; IDEX also holds the source IDs.
REQ-018 fwd_sel encoding, per source: 00 = register file, 01 = MEMWB result, 10 = EXMEM result; 11 shall never be driven.
REQ-019 For each source k of IDEX: select 10 if EXMEM is valid with regwrite and rd equal to src k; otherwise 01 if MEMWB matches under the same condition; otherwise 00 (the newer stage wins).
REQ-020 When ZERO_REG=1, a source or rd equal to 0 shall never match.
REQ-021 fwd_sel and stall shall be combinational from registered state plus the ID inputs, with zero cycles of latency.
REQ-022 stall shall be 1 when id_valid=1, IDEX is a valid load with regwrite, and any ID source matches IDEX.rd.
REQ-023 With hold=0 and stall=0, on each edge: IDEX takes the ID fields, EXMEM takes IDEX, MEMWB takes EXMEM.
REQ-024 With hold=0 and stall=1: IDEX shall take a bubble (valid=0) while EXMEM and MEMWB advance, which makes every load-use stall exactly one cycle long.
REQ-025 With hold=0 and flush=1: IDEX shall take a bubble regardless of stall; flush has priority over stall.
REQ-026 With hold=1, all entries and stall_cnt shall keep their values; hold has priority over flush and stall.
REQ-027 stall_cnt shall increment by 1 on each edge where hold=0, flush=0 and stall=1, and shall saturate at all-ones without wrapping.
REQ-028 An instruction with id_valid=0 shall enter IDEX as a bubble.

Reset
REQ-029 When rst=1, every entry's valid, regwrite and memread shall clear to 0, rd and source fields shall clear to 0, and stall_cnt shall clear to 0, asynchronously.
REQ-030 During reset, fwd_sel shall be all 00 and stall shall be 0; asserting reset mid-stall shall cancel the stall immediately.

Structure
REQ-031 The encodings FWD_RF, FWD_WB and FWD_MEM shall be defined in a shared package, fwd_pkg.
REQ-032 A sub-module fwd_src_match shall compute one source's select (REQ-019/020) and shall be instantiated NUM_SRC times by generate.

Verification
REQ-033 Scenario: IDEX rd=12, regwrite=1, then next ID src0=12, src1=15 -> one cycle later fwd_sel[1:0]=10 and fwd_sel[3:2]=00.
REQ-034 Scenario: rd=13 in MEMWB, regwrite=1; EX src1=13 -> fwd_sel[3:2]=01; with regwrite=0 -> 00.
REQ-035 Scenario: rd=12 in both EXMEM and MEMWB, EX src0=12 -> fwd_sel[1:0]=10 (EXMEM priority).
REQ-036 Scenario: load rd=11 in IDEX, ID src0=11 -> stall=1 for one cycle, a bubble enters IDEX, stall_cnt=1, then fwd_sel[1:0]=01 once the load reaches MEMWB.
REQ-037 Scenario: the REQ-036 stall with flush=1 -> bubble, stall_cnt unchanged; with hold=1 -> no state change.
REQ-038 Scenario: ZERO_REG=1 with rd=0 and src=0 -> fwd_sel=00 and stall=0; stall_cnt preset to 0xFFFF plus a further stall -> stays 0xFFFF; rst pulse -> all outputs 0.
